// File: rtl/booth_mac_acc.sv
// Frame accumulator for the Booth multiplier product bus: sums BLOCK_LEN signed
// products with saturation and presents the total on a valid/ready port.
module booth_mac_acc #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4,
  localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic [CNT_W-1:0]  cnt
);

  // state | meaning
  // ACCUM | accepting products, building the frame sum
  // HOLD  | frame complete, result presented until out_ready
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(BLOCK_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   sat_val;
  logic               sat_hit;

  // One guard bit above the accumulator exposes overflow as a sign mismatch.
  assign sum     = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign sat_hit = sum[ACC_W] ^ sum[ACC_W-1];
  assign sat_val = !sat_hit ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == ACCUM) && !rst;
    out_valid = (state_q == HOLD);
    if (clr) begin
      // Flush wins over any accept or release in the same cycle.
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc_d = sat_val;
            ovf_d = ovf_q | sat_hit;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign acc_out = acc_q;
  assign ovf     = ovf_q;
  assign cnt     = cnt_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Scoreboard bench for booth_mac_acc: a 16-bit and a 9-bit accumulator share
// one stimulus stream and are checked against a saturating reference model.
module tb_booth_mac_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] prod = '0;
  logic       out_ready = 1'b0;

  logic [1:0]  in_ready_w, out_valid_w, ovf_w;
  logic [2:0]  cnt0, cnt1;
  logic [15:0] acc0;
  logic [8:0]  acc1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {int acc; bit ovf;} res_t;
  res_t sb [2][$];

  int  m_acc  [2];
  bit  m_ovf  [2];
  int  m_cnt  [2];
  bit  m_hold [2];
  int  m_w    [2] = '{16, 9};

  always #5 clk = ~clk;

  booth_mac_acc #(.PROD_W(8), .ACC_W(16), .BLOCK_LEN(4)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .prod(prod), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .acc_out(acc0), .ovf(ovf_w[0]), .cnt(cnt0));

  booth_mac_acc #(.PROD_W(8), .ACC_W(9), .BLOCK_LEN(4)) u_dut9 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .prod(prod), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .acc_out(acc1), .ovf(ovf_w[1]), .cnt(cnt1));

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic signed [31:0] get_acc(input int k);
    if (k == 0) return 32'($signed(acc0));
    return 32'($signed(acc1));
  endfunction

  function automatic int get_cnt(input int k);
    return (k == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  function automatic int sat_add(input int a, input int p, input int w, output bit o);
    int s, mx, mn;
    s  = a + p;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    o  = 1'b0;
    if (s > mx) begin s = mx; o = 1'b1; end
    if (s < mn) begin s = mn; o = 1'b1; end
    return s;
  endfunction

  task automatic model_reset(input int k);
    m_acc[k] = 0; m_ovf[k] = 1'b0; m_cnt[k] = 0; m_hold[k] = 1'b0;
  endtask

  // Inputs change 1 time unit after posedge, so the negedge sees what the
  // next posedge will act on.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_reset(k);
        sb[k].delete();
      end else begin
        res_t r;
        bit   o;
        check($sformatf("in_ready%0d", k), 32'(in_ready_w[k]), 32'(!m_hold[k]));
        check($sformatf("out_valid%0d", k), 32'(out_valid_w[k]), 32'(m_hold[k]));
        check($sformatf("acc%0d", k), get_acc(k), m_acc[k]);
        check($sformatf("ovf%0d", k), 32'(ovf_w[k]), 32'(m_ovf[k]));
        check($sformatf("cnt%0d", k), get_cnt(k), m_cnt[k]);
        if (clr) begin
          if (m_hold[k] && sb[k].size() > 0) void'(sb[k].pop_front());
          model_reset(k);
        end else if (m_hold[k]) begin
          if (out_ready) begin
            if (sb[k].size() == 0) begin
              check($sformatf("sb_empty%0d", k), 1, 0);
            end else begin
              r = sb[k].pop_front();
              check($sformatf("result_acc%0d", k), get_acc(k), r.acc);
              check($sformatf("result_ovf%0d", k), 32'(ovf_w[k]), 32'(r.ovf));
            end
            model_reset(k);
          end
        end else if (in_valid) begin
          m_acc[k] = sat_add(m_acc[k], int'($signed(prod)), m_w[k], o);
          m_ovf[k] = m_ovf[k] | o;
          m_cnt[k]++;
          if (m_cnt[k] == 4) begin
            m_hold[k] = 1'b1;
            r.acc = m_acc[k];
            r.ovf = m_ovf[k];
            sb[k].push_back(r);
          end
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] p, input logic ordy, input logic c);
    in_valid = v; prod = p; out_ready = ordy; clr = c;
    @(posedge clk); #1;
  endtask

  logic [7:0] frame1 [4] = '{8'h06, 8'hF4, 8'h31, 8'h80};

  initial begin
    #1;
    check("rst_acc", 32'(acc0), 0);
    check("rst_out_valid", 32'(out_valid_w[0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready_w[0]), 1);
    @(posedge clk); #1;

    // basic frame, immediate release
    for (int i = 0; i < 4; i++) cyc(1'b1, frame1[i], 1'b1, 1'b0);
    check("t1_valid", 32'(out_valid_w[0]), 1);
    check("t1_acc", get_acc(0), -85);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_back", 32'(in_ready_w[0]), 1);

    // backpressure with in_valid held high
    for (int i = 0; i < 4; i++) cyc(1'b1, frame1[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0);
    check("t2_cnt", get_cnt(0), 4);
    check("t2_acc", 32'(acc0), 32'h0000FFAB);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_clean", get_acc(0), 0);

    // positive then negative saturation (9-bit instance)
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h7F, 1'b0, 1'b0);
    check("t3_clamp3", 32'(acc1), 32'h0FF);
    cyc(1'b1, 8'h7F, 1'b0, 1'b0);
    check("t3_ovf", 32'(ovf_w[1]), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h80, 1'b0, 1'b0);
    check("t4_acc", get_acc(1), -256);
    check("t4_ovf", 32'(ovf_w[1]), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // clr drops the coincident product
    cyc(1'b1, 8'h10, 1'b1, 1'b0);
    cyc(1'b1, 8'h10, 1'b1, 1'b0);
    cyc(1'b1, 8'h10, 1'b1, 1'b1);
    check("t5_acc", get_acc(0), 0);
    check("t5_cnt", get_cnt(0), 0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    check("t5_frame", get_acc(0), 10);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // async reset mid-frame
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h21, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_acc", 32'(acc0), 0);
    check("t6_cnt", get_cnt(0), 0);
    check("t6_ovf", 32'(ovf_w[1]), 0);
    check("t6_valid", 32'(out_valid_w[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_ready", 32'(in_ready_w[0]), 1);
    @(posedge clk); #1;

    // random gaps, backpressure and occasional flush
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 39) == 0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("sb_drained0", sb[0].size(), 0);
    check("sb_drained1", sb[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
